// File: rtl/gearbox_serializer.sv
// gearbox_serializer: width-down serializer that splits IN_WIDTH-bit words into
// RATIO = IN_WIDTH/OUT_WIDTH slices of OUT_WIDTH bits, MSB-first or LSB-first.
// A current-word shift register plus a one-word prefetch register keep in_ready
// registered while sustaining one slice per clock across word boundaries.
// Optional feature macro: GEARBOX_NSLICES_EN adds in_nslices, a per-word slice
// count (0 or values above RATIO mean RATIO).
module gearbox_serializer #(
    parameter int  IN_WIDTH  = 64,
    parameter int  OUT_WIDTH = 8,
    parameter int  MSB_FIRST = 1,
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
    localparam int CW        = $clog2(RATIO + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
`ifdef GEARBOX_NSLICES_EN
    input  logic [CW-1:0]        in_nslices,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last
);

    localparam logic [CW-1:0] RATIO_M1 = CW'(RATIO - 1);
    localparam logic [CW-1:0] ONE_CW   = CW'(1);
    localparam logic [CW-1:0] ZERO_CW  = CW'(0);

    // Reject ratios the slicing logic cannot represent.
    if ((RATIO < 2) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_ratio
        $error("gearbox_serializer: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
    end

`ifdef GEARBOX_NSLICES_EN
    localparam logic [CW-1:0] RATIO_CW = CW'(RATIO);

    // Map a requested slice count to the index of the word's final slice.
    function automatic logic [CW-1:0] nslices_to_last_idx(input logic [CW-1:0] n);
        logic [CW-1:0] r;
        if ((n == ZERO_CW) || (n > RATIO_CW)) begin
            r = RATIO_M1;
        end else begin
            r = n - ONE_CW;
        end
        return r;
    endfunction
`endif

    // Current word being sliced
    logic [IN_WIDTH-1:0] cur_q, cur_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       cur_nm1_q, cur_nm1_d;
    logic                cur_valid_q, cur_valid_d;
    logic                cur_last_q, cur_last_d;
    // Prefetched next word
    logic [IN_WIDTH-1:0] nxt_q, nxt_d;
    logic [CW-1:0]       nxt_nm1_q, nxt_nm1_d;
    logic                nxt_valid_q, nxt_valid_d;
    logic                nxt_last_q, nxt_last_d;
    // Registered handshake outputs
    logic                in_ready_q, in_ready_d;
    logic                out_last_q, out_last_d;

    logic                in_fire_s;
    logic                out_fire_s;
    logic                last_slice_s;
    logic                to_cur_s;
    logic [CW-1:0]       in_nm1_s;
    logic [IN_WIDTH-1:0] shift_s;

`ifdef GEARBOX_NSLICES_EN
    assign in_nm1_s = nslices_to_last_idx(in_nslices);
`else
    assign in_nm1_s = RATIO_M1;
`endif

    if (MSB_FIRST != 0) begin : g_msb
        assign shift_s  = cur_q << OUT_WIDTH;
        assign out_data = cur_q[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
        assign shift_s  = cur_q >> OUT_WIDTH;
        assign out_data = cur_q[OUT_WIDTH-1:0];
    end

    assign out_valid = cur_valid_q;
    assign out_last  = out_last_q;
    assign in_ready  = in_ready_q;

    // Next-state logic: slice advance, word retire/reload, and input steering.
    always_comb begin
        in_fire_s    = in_valid && in_ready_q;
        out_fire_s   = cur_valid_q && out_ready;
        last_slice_s = (cnt_q == cur_nm1_q);
        to_cur_s     = 1'b0;

        cur_d       = cur_q;
        cnt_d       = cnt_q;
        cur_nm1_d   = cur_nm1_q;
        cur_valid_d = cur_valid_q;
        cur_last_d  = cur_last_q;
        nxt_d       = nxt_q;
        nxt_nm1_d   = nxt_nm1_q;
        nxt_valid_d = nxt_valid_q;
        nxt_last_d  = nxt_last_q;

        if (out_fire_s && !last_slice_s) begin
            cur_d = shift_s;
            cnt_d = cnt_q + ONE_CW;
        end else if (out_fire_s) begin
            // Final slice retires; reload from prefetch first, then the bypass input.
            cnt_d = ZERO_CW;
            if (nxt_valid_q) begin
                cur_d       = nxt_q;
                cur_nm1_d   = nxt_nm1_q;
                cur_last_d  = nxt_last_q;
                nxt_valid_d = 1'b0;
                nxt_last_d  = 1'b0;
            end else if (in_fire_s) begin
                cur_d      = in_data;
                cur_nm1_d  = in_nm1_s;
                cur_last_d = in_last;
                to_cur_s   = 1'b1;
            end else begin
                cur_valid_d = 1'b0;
                cur_last_d  = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (in_fire_s && !cur_valid_q) begin
            // Idle: the word goes straight into the shift register.
            cur_d       = in_data;
            cur_nm1_d   = in_nm1_s;
            cur_last_d  = in_last;
            cur_valid_d = 1'b1;
            cnt_d       = ZERO_CW;
        end else if (in_fire_s && !to_cur_s) begin
            nxt_d       = in_data;
            nxt_nm1_d   = in_nm1_s;
            nxt_last_d  = in_last;
            nxt_valid_d = 1'b1;
        end else begin
            nxt_valid_d = nxt_valid_d;
        end

        in_ready_d = !nxt_valid_d;
        out_last_d = cur_valid_d && cur_last_d && (cnt_d == cur_nm1_d);
    end

    // State registers; reset drops any buffered words immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= {IN_WIDTH{1'b0}};
            cnt_q       <= ZERO_CW;
            cur_nm1_q   <= RATIO_M1;
            cur_valid_q <= 1'b0;
            cur_last_q  <= 1'b0;
            nxt_q       <= {IN_WIDTH{1'b0}};
            nxt_nm1_q   <= RATIO_M1;
            nxt_valid_q <= 1'b0;
            nxt_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_last_q  <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            cur_nm1_q   <= cur_nm1_d;
            cur_valid_q <= cur_valid_d;
            cur_last_q  <= cur_last_d;
            nxt_q       <= nxt_d;
            nxt_nm1_q   <= nxt_nm1_d;
            nxt_valid_q <= nxt_valid_d;
            nxt_last_q  <= nxt_last_d;
            in_ready_q  <= in_ready_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_gearbox_serializer.sv
// tb_gearbox_serializer: directed bench driving one MSB-first and one LSB-first
// 32->8 serializer from the same stimulus and comparing against hand-computed
// slice sequences.
module tb_gearbox_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;
`ifdef GEARBOX_NSLICES_EN
    logic [2:0]  in_nslices;
`endif
    logic        in_ready_m, in_ready_l;
    logic        out_valid_m, out_valid_l;
    logic [7:0]  out_data_m, out_data_l;
    logic        out_last_m, out_last_l;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] w_data [4];
    logic        w_last [4];
    logic [2:0]  w_ns   [4];

    gearbox_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data), .in_last(in_last),
`ifdef GEARBOX_NSLICES_EN
        .in_nslices(in_nslices),
`endif
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m), .out_last(out_last_m)
    );

    gearbox_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data), .in_last(in_last),
`ifdef GEARBOX_NSLICES_EN
        .in_nslices(in_nslices),
`endif
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l), .out_last(out_last_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feed nw words back-to-back (source holds each until accepted) and check the
    // slice stream; em/el hold the expected bytes left-aligned.
    task automatic run_words(input int nw, input logic [127:0] em, input logic [127:0] el,
                             input int nexp, input int last_idx);
        int   idx   = 0;
        int   got   = 0;
        int   first = -1;
        int   lastc = -1;
        logic fired = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (fired) idx++;
            if (out_valid_m) begin
                if (got < nexp) begin
                    check_eq("stream_msb", 32'(out_data_m), 32'(em[127-8*got -: 8]));
                    check_eq("stream_lsb", 32'(out_data_l), 32'(el[127-8*got -: 8]));
                    check_eq("stream_last", 32'(out_last_m), 32'(got == last_idx));
                    check_eq("stream_last_l", 32'(out_last_l), 32'(got == last_idx));
                end
                if (first < 0) first = c;
                lastc = c;
                got++;
            end
            if (idx < nw) begin
                in_valid = 1'b1;
                in_data  = w_data[idx];
                in_last  = w_last[idx];
`ifdef GEARBOX_NSLICES_EN
                in_nslices = w_ns[idx];
`endif
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            fired = in_valid && in_ready_m;
        end
        check_eq("stream_count", 32'(got), 32'(nexp));
        check_eq("stream_no_gap", 32'(lastc - first + 1), 32'(nexp));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
`ifdef GEARBOX_NSLICES_EN
        in_nslices = 3'd0;
`endif
        for (int i = 0; i < 4; i++) w_ns[i] = 3'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid_m), 32'd0);
        check_eq("rst_out_data", 32'(out_data_m), 32'd0);
        check_eq("rst_out_last", 32'(out_last_m), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready_m), 32'd1);
        check_eq("rst_out_valid_l", 32'(out_valid_l), 32'd0);
        check_eq("rst_in_ready_l", 32'(in_ready_l), 32'd1);
        rst_n = 1'b1;

        // Slice order, single word: MSB-first AA BB CC DD, LSB-first DD CC BB AA
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hAABBCCDD; in_last = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] em;
            logic [31:0] el;
            em = 32'hAABBCCDD;
            el = 32'hDDCCBBAA;
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("order_valid", 32'(out_valid_m), 32'd1);
            check_eq("order_msb", 32'(out_data_m), 32'(em[31-8*k -: 8]));
            check_eq("order_lsb", 32'(out_data_l), 32'(el[31-8*k -: 8]));
            check_eq("order_last", 32'(out_last_m), 32'd0);
        end
        @(negedge clk);
        check_eq("order_done_m", 32'(out_valid_m), 32'd0);
        check_eq("order_done_l", 32'(out_valid_l), 32'd0);

        // Back-to-back: three words, last flag on the third
        w_data[0] = 32'h01020304; w_last[0] = 1'b0;
        w_data[1] = 32'h05060708; w_last[1] = 1'b0;
        w_data[2] = 32'h090A0B0C; w_last[2] = 1'b1;
        run_words(3, 128'h0102030405060708090A0B0C00000000,
                     128'h04030201080706050C0B0A0900000000, 12, 11);

        // Backpressure: hold after first slice, second word parks in prefetch
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hAABBCCDD; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_first_msb", 32'(out_data_m), 32'hAA);
        check_eq("bp_first_lsb", 32'(out_data_l), 32'hDD);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11223344;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check_eq("bp_in_ready_low", 32'(in_ready_m), 32'd0);
            check_eq("bp_hold_valid", 32'(out_valid_m), 32'd1);
            check_eq("bp_hold_msb", 32'(out_data_m), 32'hAA);
            check_eq("bp_hold_lsb", 32'(out_data_l), 32'hDD);
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            logic [55:0] em;
            logic [55:0] el;
            em = 56'hBBCCDD11223344;
            el = 56'hCCBBAA44332211;
            @(negedge clk);
            check_eq("bp_resume_valid", 32'(out_valid_m), 32'd1);
            check_eq("bp_resume_msb", 32'(out_data_m), 32'(em[55-8*k -: 8]));
            check_eq("bp_resume_lsb", 32'(out_data_l), 32'(el[55-8*k -: 8]));
        end
        @(negedge clk);
        check_eq("bp_drained", 32'(out_valid_m), 32'd0);
        check_eq("bp_in_ready_back", 32'(in_ready_m), 32'd1);

        // Reset mid-word with a prefetched word pending
        in_valid = 1'b1; in_data = 32'hAABBCCDD;
        @(negedge clk);
        in_data = 32'h11223344;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rmw_pre_msb", 32'(out_data_m), 32'hCC);
        rst_n = 1'b0;
        #1;
        check_eq("rmw_out_valid", 32'(out_valid_m), 32'd0);
        check_eq("rmw_in_ready", 32'(in_ready_m), 32'd1);
        check_eq("rmw_out_data", 32'(out_data_m), 32'd0);
        check_eq("rmw_out_valid_l", 32'(out_valid_l), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rmw_idle", 32'(out_valid_m), 32'd0);
        in_valid = 1'b1; in_data = 32'h55667788;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] em;
            logic [31:0] el;
            em = 32'h55667788;
            el = 32'h88776655;
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("rmw_valid", 32'(out_valid_m), 32'd1);
            check_eq("rmw_msb", 32'(out_data_m), 32'(em[31-8*k -: 8]));
            check_eq("rmw_lsb", 32'(out_data_l), 32'(el[31-8*k -: 8]));
        end
        @(negedge clk);
        check_eq("rmw_done", 32'(out_valid_m), 32'd0);

`ifdef GEARBOX_NSLICES_EN
        // Per-word slice count: 2 slices, then 0 meaning the full ratio
        w_data[0] = 32'hAABBCCDD; w_last[0] = 1'b0; w_ns[0] = 3'd2;
        w_data[1] = 32'h11223344; w_last[1] = 1'b1; w_ns[1] = 3'd0;
        run_words(2, 128'hAABB1122334400000000000000000000,
                     128'hDDCC4433221100000000000000000000, 6, 5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Bound the whole run in case the design stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
